// File: rtl/ads1675_pkg.sv
// ads1675_pkg
//   Shared types and constants for the ADS1675 decimating framer.
//   ADS_DW     default sample width
//   ADS_OVF_W  width of the saturating overflow counter
//   ads_sample_t / ads_entry_t  sample and output-buffer entry types
//   sat_inc    saturating increment for the overflow counter
package ads1675_pkg;

    localparam int ADS_DW    = 32;
    localparam int ADS_OVF_W = 16;

    typedef logic signed [ADS_DW-1:0] ads_sample_t;

    typedef struct packed {
        ads_sample_t data;
        logic        last;
    } ads_entry_t;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [ADS_OVF_W-1:0] sat_inc(input logic [ADS_OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ads1675_axis_buf2.sv
// ads1675_axis_buf2
//   Two-entry FIFO feeding an AXI-Stream master. The head entry drives the
//   output directly, so data and last stay stable while the head is waiting.
//   Ports:
//     sclk, rst_n  clock, asynchronous active-low reset
//     push         store push_data (ignored when full and not popping)
//     push_data    entry to store
//     pop          consume the head entry (only meaningful when valid)
//     full         both entries occupied
//     valid        at least one entry occupied
//     head         oldest entry
import ads1675_pkg::*;

module ads1675_axis_buf2 #(
    parameter type entry_t = ads_entry_t
) (
    input  logic   sclk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   valid,
    output entry_t head
);

    entry_t     ent0;   // head
    entry_t     ent1;   // second in line
    logic [1:0] count;

    // NOTE: the two entries are reset, not left uninitialised, because the
    // head drives the output data, which must read zero out of reset.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        ent0  <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0 <= push_data;
                    end else if (push) begin
                        ent1  <= push_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a push is only taken together with a pop.
                    if (pop) begin
                        ent0 <= ent1;
                        if (push) begin
                            ent1 <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign full  = (count == 2'd2);
    assign valid = (count != 2'd0);
    assign head  = ent0;

endmodule

// File: rtl/ads1675_decim_framer.sv
// ads1675_decim_framer
//   Boxcar-averages every DECIM signed input samples into one output word,
//   marks every FRAME-th stored word with TLAST and buffers two words
//   against DMA backpressure. Results that find the buffer full are
//   dropped and counted, since the ADC cannot be stalled.
//   Ports:
//     sclk, rst_n        sole clock, asynchronous active-low reset
//     en                 run enable; low clears accumulation and framing
//     s_axis_*           sample input (tlast ignored, tready high after reset)
//     m_axis_*           averaged output to the DMA
//     overflow_cnt       number of dropped results, saturating
import ads1675_pkg::*;

module ads1675_decim_framer #(
    parameter int DW         = ADS_DW,
    parameter int LOG2_DECIM = 3,
    parameter int FRAME      = 2500
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic signed [DW-1:0] s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic signed [DW-1:0] m_axis_tdata,
    output logic [ADS_OVF_W-1:0] overflow_cnt
);

    localparam int DECIM = 1 << LOG2_DECIM;
    localparam int AW    = DW + LOG2_DECIM;

    typedef struct packed {
        logic signed [DW-1:0] data;
        logic                 last;
    } entry_t;

    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_sum;
    logic [LOG2_DECIM-1:0]  phase;
    logic [15:0]            frame_cnt;

    logic   accept;
    logic   closing;
    logic   pop;
    logic   full;
    logic   store;
    logic   drop;
    entry_t push_entry;
    entry_t head;

    // Upstream packet boundaries carry no meaning here.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign accept  = s_axis_tvalid && s_axis_tready;
    assign closing = accept && en && (phase == LOG2_DECIM'(DECIM - 1));
    assign acc_sum = acc + {{LOG2_DECIM{s_axis_tdata[DW-1]}}, s_axis_tdata};
    assign pop     = m_axis_tvalid && m_axis_tready;
    assign store   = closing && (!full || pop);
    assign drop    = closing && full && !pop;

    // NOTE: every field gets a default before any condition, so no latch
    // can be inferred for the entry being pushed.
    always_comb begin
        push_entry      = '0;
        // Dropping the low LOG2_DECIM bits of a signed sum is an arithmetic
        // shift right, i.e. floor division by DECIM.
        push_entry.data = acc_sum[AW-1:LOG2_DECIM];
        push_entry.last = (frame_cnt == 16'(FRAME - 1));
    end

    // Ready is held low only during reset and the edge that releases it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every block
    // sees the pre-edge values of the others, whatever the evaluation order.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            phase     <= '0;
            frame_cnt <= '0;
        end else if (!en) begin
            acc       <= '0;
            phase     <= '0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                if (closing) begin
                    acc   <= '0;
                    phase <= '0;
                end else begin
                    acc   <= acc_sum;
                    phase <= phase + 1'b1;
                end
            end
            // Only results that actually land in the buffer advance framing.
            if (store) begin
                frame_cnt <= push_entry.last ? 16'd0 : frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (drop) begin
            overflow_cnt <= sat_inc(overflow_cnt);
        end
    end

    ads1675_axis_buf2 #(
        .entry_t (entry_t)
    ) u_buf (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .push      (store),
        .push_data (push_entry),
        .pop       (pop),
        .full      (full),
        .valid     (m_axis_tvalid),
        .head      (head)
    );

    assign m_axis_tdata = head.data;
    assign m_axis_tlast = head.last;

endmodule

// File: tb/tb_ads1675_decim_framer.sv
// tb_ads1675_decim_framer
//   Directed scenarios plus a randomized run, all checked every cycle
//   against a queue-based reference of averaging, framing and buffering.
module tb_ads1675_decim_framer;

    localparam int L     = 3;
    localparam int DECIM = 1 << L;
    localparam int FRAME = 4;

    logic               sclk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tlast = 1'b0;
    logic signed [31:0] s_axis_tdata = '0;
    logic               m_axis_tready = 1'b0;
    logic               s_axis_tready;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic signed [31:0] m_axis_tdata;
    logic [15:0]        overflow_cnt;

    ads1675_decim_framer #(
        .DW         (32),
        .LOG2_DECIM (L),
        .FRAME      (FRAME)
    ) dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .en            (en),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 sclk = ~sclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t   q_m[$];
    longint samples_m[$];
    int     frame_m;
    int     ovf_m;
    bit     rdy_m;

    // Words actually handed to the DMA, for the directed scenarios.
    int got_d[$];
    bit got_l[$];

    function automatic int floor_avg(input longint s[$]);
        longint sum = 0;
        longint q;
        foreach (s[i]) sum += s[i];
        q = sum / DECIM;
        if ((sum % DECIM != 0) && (sum < 0)) q -= 1;
        return int'(q);
    endfunction

    task automatic model_reset();
        q_m.delete();
        samples_m.delete();
        frame_m = 0;
        ovf_m   = 0;
        rdy_m   = 1'b0;
    endtask

    task automatic model_step(input bit v, input int d, input bit e, input bit r);
        bit   pop;
        bit   have;
        exp_t res;
        pop  = (q_m.size() > 0) && r;
        have = 1'b0;
        if (!e) begin
            samples_m.delete();
            frame_m = 0;
        end else if (v && rdy_m) begin
            samples_m.push_back(longint'(d));
            if (samples_m.size() == DECIM) begin
                res.data = floor_avg(samples_m);
                have     = 1'b1;
                samples_m.delete();
            end
        end
        if (pop) void'(q_m.pop_front());
        if (have) begin
            if (q_m.size() < 2) begin
                res.last = (frame_m == FRAME - 1);
                q_m.push_back(res);
                frame_m = (frame_m + 1) % FRAME;
            end else if (ovf_m < 65535) begin
                ovf_m++;
            end
        end
        rdy_m = 1'b1;
    endtask

    // One clock: drive after a falling edge, model the rising edge, check
    // on the next falling edge.
    task automatic cycle(input bit v, input int d, input bit e, input bit r);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        en            = e;
        m_axis_tready = r;
        #1;
        if (m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(int'(m_axis_tdata));
            got_l.push_back(m_axis_tlast);
        end
        @(posedge sclk);
        model_step(v, d, e, r);
        @(negedge sclk);
        check("s_tready", longint'(s_axis_tready), longint'(rdy_m));
        check("m_tvalid", longint'(m_axis_tvalid), longint'(q_m.size() > 0));
        if (q_m.size() > 0) begin
            check("m_tdata", longint'(m_axis_tdata), longint'(q_m[0].data));
            check("m_tlast", longint'(m_axis_tlast), longint'(q_m[0].last));
        end
        check("ovf_cnt", longint'(overflow_cnt), longint'(ovf_m));
    endtask

    // Asserts reset right now (possibly mid-cycle), checks the outputs
    // react at once, releases on a falling edge and idles one cycle.
    task automatic do_reset();
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        en            = 1'b0;
        m_axis_tready = 1'b0;
        model_reset();
        #1;
        check("rst_s_tready", longint'(s_axis_tready), 0);
        check("rst_m_tvalid", longint'(m_axis_tvalid), 0);
        check("rst_m_tlast", longint'(m_axis_tlast), 0);
        check("rst_m_tdata", longint'(m_axis_tdata), 0);
        check("rst_ovf", longint'(overflow_cnt), 0);
        @(negedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        cycle(1'b0, 0, 1'b1, 1'b1);
        got_d.delete();
        got_l.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic check_got(input string tag, input int exp_d[$], input bit exp_l[$]);
        check({tag, "_count"}, longint'(got_d.size()), longint'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                check({tag, "_data"}, longint'(got_d[i]), longint'(exp_d[i]));
                check({tag, "_last"}, longint'(got_l[i]), longint'(exp_l[i]));
            end
        end
    endtask

    initial begin
        int  v_int;
        bit  rv;
        bit  re;
        bit  rr;

        @(negedge sclk);

        // Ramp 1..32 with FRAME=4: averages 4,12,20,28, TLAST on 28.
        do_reset();
        for (int i = 1; i <= 32; i++) cycle(1'b1, i, 1'b1, 1'b1);
        drain(3);
        check_got("ramp", '{4, 12, 20, 28}, '{0, 0, 0, 1});

        // Floor rounding of a negative sum: -3/8 -> -1.
        do_reset();
        for (int i = 0; i < DECIM; i++) cycle(1'b1, (i == 0) ? -1 : ((i == 1) ? -2 : 0), 1'b1, 1'b1);
        drain(2);
        check_got("neg", '{-1}, '{0});

        // Full-scale inputs average back to themselves without wrapping.
        do_reset();
        v_int = int'(32'h7FFF_FFFF);
        for (int i = 0; i < DECIM; i++) cycle(1'b1, v_int, 1'b1, 1'b1);
        v_int = int'(32'h8000_0000);
        for (int i = 0; i < DECIM; i++) cycle(1'b1, v_int, 1'b1, 1'b1);
        drain(2);
        check_got("extreme", '{int'(32'h7FFF_FFFF), int'(32'h8000_0000)}, '{0, 0});

        // Three results under backpressure: third dropped; TLAST then
        // lands on the fourth stored word.
        do_reset();
        for (int i = 0; i < 3 * DECIM; i++) cycle(1'b1, 10 * (i / DECIM + 1), 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("bp_ovf", longint'(overflow_cnt), 1);
        for (int i = 0; i < 2 * DECIM; i++) cycle(1'b1, 10 * (i / DECIM + 4), 1'b1, 1'b1);
        drain(3);
        check_got("bp", '{10, 20, 40, 50}, '{0, 0, 0, 1});

        // Full buffer with pop and push on the same edge: nothing dropped.
        do_reset();
        for (int i = 0; i < 3 * DECIM; i++) cycle(1'b1, 10 * (i / DECIM + 1), 1'b1, i == 3 * DECIM - 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
        check("simul_ovf", longint'(overflow_cnt), 0);
        drain(3);
        check_got("simul", '{10, 20, 30}, '{0, 0, 0});

        // en drops after 5 samples: partial sum discarded.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5000, 1'b0, 1'b1);
        for (int i = 0; i < DECIM; i++) cycle(1'b1, 100 + i, 1'b1, 1'b1);
        drain(2);
        check_got("en_drop", '{103}, '{0});

        // Reset mid-frame with a full buffer and a nonzero drop count.
        do_reset();
        for (int i = 0; i < 3 * DECIM; i++) cycle(1'b1, 10 * (i / DECIM + 1), 1'b1, 1'b0);
        check("pre_rst_ovf", longint'(overflow_cnt), 1);
        #2;
        do_reset();

        // Randomized traffic, enable and backpressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 59) != 0);
            rr = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       v_int = int'(32'h7FFF_FFFF);
                1:       v_int = int'(32'h8000_0000);
                2:       v_int = int'($urandom_range(0, 15)) - 8;
                default: v_int = int'($urandom);
            endcase
            cycle(rv, v_int, re, rr);
        end
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ads1675_decim_framer.md
Name: ads1675_decim_framer

Overview:
- Downstream stage of the ADS1675 source. Consumes its 32-bit signed AXI-Stream samples in the sclk domain.
- Boxcar-averages every DECIM samples into one output word.
- Re-frames outputs with TLAST every FRAME words for the DMA.
- A 2-entry output buffer absorbs DMA backpressure. Results that cannot be stored are dropped and counted, because the ADC cannot be stalled.

Parameters:
- DW, 32, input/output sample width (signed).
- LOG2_DECIM, 3, log2 of decimation ratio; legal 1..8.
- DECIM, 1<<LOG2_DECIM, samples averaged per output (derived, not overridden).
- FRAME, 2500, output words per TLAST packet; legal 2..65535.

Ports:
- sclk  in  1  ADC bit clock, sole clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  upstream packet marker; ignored.
- s_axis_tdata  in  DW  signed input sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  DMA ready.
- m_axis_tlast  out  1  last word of FRAME packet.
- m_axis_tdata  out  DW  signed averaged sample.
- overflow_cnt  out  16  dropped-result count, saturating.

Behaviour:
- Clock and reset: one clock, sclk. Reset is asynchronous and active-low on rst_n.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow_cnt=0. Accumulator, phase counter, frame counter and buffer are all cleared/empty.
- s_axis_tready is 1 from the first cycle after reset release and stays 1. An input is accepted when s_axis_tvalid and s_axis_tready are both high.
- en=0:
  - Accumulator, phase counter and frame counter are cleared synchronously.
  - Accepted inputs are discarded.
  - The buffer keeps draining normally.
  - overflow_cnt holds its value.
- Accumulator width is DW+LOG2_DECIM, signed. Each input is sign-extended before being added.
- Phase counter counts 0..DECIM-1 and increments on each accepted input while en=1.
- On the input that takes phase to DECIM-1 (the "closing" input):
  - result = (acc + sample) >>> LOG2_DECIM, arithmetic shift, floor rounding, low DW bits.
  - The accumulator reloads to 0 and phase returns to 0.
- Latency: closing input accepted at cycle k → result is in the buffer at k+1. If the buffer was empty, m_axis_tvalid=1 with that data at k+1.
- Output buffer (2 entries, FIFO order):
  - m_axis_* is driven from the head entry.
  - Pop when m_axis_tvalid && m_axis_tready.
  - A push when full with a simultaneous pop is accepted; occupancy stays 2.
  - A push when full with no pop drops the result: overflow_cnt increments, saturating at 16'hFFFF.
- Frame counter:
  - Counts stored results 0..FRAME-1. Dropped results do not advance it.
  - The stored entry with count FRAME-1 carries tlast=1, then the count wraps to 0.
  - tlast is stored per entry and travels with its data.
- AXIS hold rule: while m_axis_tvalid=1 and m_axis_tready=0, tdata and tlast stay stable.
- Reset mid-operation: everything returns to reset values immediately. A partial packet is lost with no TLAST emitted.
- en falling mid-accumulation: the partial sum is discarded. The next result after en rises uses a full DECIM fresh samples, and the frame count restarts at 0.

Decomposition:
- Shared package ads1675_pkg:
  - ADS_DW=32, ADS_OVF_W=16.
  - A typedef for signed DW sample.
  - A typedef for the buffer entry struct {data, last}.
- Sub-module ads1675_axis_buf2: the 2-entry AXIS FIFO with push/full/pop.
- The top holds the accumulator, phase counter, frame counter and overflow counter.

Test Plan:
- LOG2_DECIM=3, FRAME=4, tready=1, inputs 1..32 each cycle → outputs floor avg 4,12,20,28; tlast only on 28; each output appears 1 cycle after samples 8,16,24,32.
- Negative rounding: inputs −1,−2,0,0,0,0,0,0 → output −1 (floor of −3/8), not 0.
- Extreme values: 8 inputs of 32'h7FFFFFFF → 32'h7FFFFFFF; 8 inputs of 32'h80000000 → 32'h80000000; no wrap.
- Backpressure: tready=0 for 3 results → 2 held stable in order, 3rd dropped, overflow_cnt=1. With FRAME=4, subsequent tlast lands on the 4th stored word, not the 4th produced.
- Full with simultaneous pop and push → no drop, overflow_cnt unchanged, order preserved.
- en drops after 5 samples, rises again → first output averages the 8 post-enable samples. Separately, rst_n asserted mid-frame → all outputs 0 in the same cycle; after release tready=1 next cycle.
